// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART MMIO loader: FSM state encoding, command
// bytes and the default frame start marker.
package uart_loader_pkg;

  localparam logic [2:0] S_SYNC  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_HALT  = 8'h48;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Only these states count idle time and can be aborted by a timeout.
  function automatic logic in_frame_body(input logic [2:0] state);
    return (state == S_CMD) || (state == S_ADDR) ||
           (state == S_DATA) || (state == S_CHK);
  endfunction

endpackage

// File: rtl/uart_frame_shifter.sv
// Little-endian 32-bit byte shift register with a 2-bit byte index and a
// running XOR checksum; reused for the ADDR field and then the DATA field.
module uart_frame_shifter (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        xor_en,
  input  logic [7:0]  rx_byte,
  output logic [31:0] word,
  output logic [1:0]  idx,
  output logic [7:0]  chk
);

  logic [31:0] word_reg;
  logic [31:0] word_next;
  logic [1:0]  idx_reg;
  logic [7:0]  chk_reg;

  // Newest byte enters the top lane, so after four shifts the first byte
  // received sits in bits [7:0].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi == 3) begin : g_top
        assign word_next[8*gi +: 8] = rx_byte;
      end else begin : g_low
        assign word_next[8*gi +: 8] = word_reg[8*(gi+1) +: 8];
      end
    end
  endgenerate

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      word_reg <= 32'd0;
      idx_reg  <= 2'd0;
      chk_reg  <= 8'd0;
    end else if (clear) begin
      idx_reg  <= 2'd0;
      chk_reg  <= 8'd0;
    end else begin
      if (shift_en) begin
        word_reg <= word_next;
        idx_reg  <= idx_reg + 2'd1;
      end
      if (xor_en) begin
        chk_reg <= chk_reg ^ rx_byte;
      end
    end
  end

  assign word = word_reg;
  assign idx  = idx_reg;
  assign chk  = chk_reg;

endmodule

// File: rtl/uart_mmio_loader.sv
// Parses UART byte frames into checksum-verified 32-bit MMIO writes and CPU
// reset control. Optional inter-byte timeout: UART_MMIO_LOADER_TIMEOUT_EN.
module uart_mmio_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter logic [23:0] TIMEOUT_CLKS = 24'd1_000_000
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Mem_Valid,
  output logic [31:0] o_Mem_Addr,
  output logic [31:0] o_Mem_WData,
  output logic [3:0]  o_Mem_WStrb,
  input  logic        i_Mem_Ready,
  output logic        o_Cpu_Rst_n,
  output logic        o_Err_Pulse,
  output logic [15:0] o_Wr_Count
);

  logic [2:0]  state_reg;
  logic [7:0]  cmd_reg;
  logic [31:0] addr_reg;
  logic        mem_valid_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_wstrb_reg;
  logic        cpu_rst_n_reg;
  logic        err_reg;
  logic [15:0] wr_count_reg;

  logic        sh_clear;
  logic        sh_shift;
  logic        sh_xor;
  logic [31:0] sh_word;
  logic [1:0]  sh_idx;
  logic [7:0]  sh_chk;
  logic        tmo_hit;

  // CMD and all payload bytes feed the checksum; only payload bytes shift.
  assign sh_clear = i_Rx_DV && (state_reg == S_SYNC) && (i_Rx_Byte == SYNC_BYTE);
  assign sh_xor   = i_Rx_DV && ((state_reg == S_CMD) || (state_reg == S_ADDR) ||
                                (state_reg == S_DATA));
  assign sh_shift = i_Rx_DV && ((state_reg == S_ADDR) || (state_reg == S_DATA));

  uart_frame_shifter u_shifter (
    .i_Clock  (i_Clock),
    .i_Rst_n  (i_Rst_n),
    .clear    (sh_clear),
    .shift_en (sh_shift),
    .xor_en   (sh_xor),
    .rx_byte  (i_Rx_Byte),
    .word     (sh_word),
    .idx      (sh_idx),
    .chk      (sh_chk)
  );

`ifdef UART_MMIO_LOADER_TIMEOUT_EN
  logic [23:0] tmo_reg;

  // Abort on the edge where the idle count would reach TIMEOUT_CLKS.
  assign tmo_hit = !i_Rx_DV && in_frame_body(state_reg) &&
                   (tmo_reg == TIMEOUT_CLKS - 24'd1);

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      tmo_reg <= 24'd0;
    end else if (i_Rx_DV || tmo_hit) begin
      tmo_reg <= 24'd0;
    end else if (in_frame_body(state_reg)) begin
      tmo_reg <= tmo_reg + 24'd1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CLKS;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_reg     <= S_SYNC;
      cmd_reg       <= 8'd0;
      addr_reg      <= 32'd0;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      mem_wstrb_reg <= 4'd0;
      cpu_rst_n_reg <= 1'b0;
      err_reg       <= 1'b0;
      wr_count_reg  <= 16'd0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        S_SYNC: begin
          if (sh_clear) state_reg <= S_CMD;
        end
        S_CMD: begin
          if (i_Rx_DV) begin
            cmd_reg <= i_Rx_Byte;
            if (i_Rx_Byte == CMD_WRITE) begin
              state_reg <= S_ADDR;
            end else if ((i_Rx_Byte == CMD_GO) || (i_Rx_Byte == CMD_HALT)) begin
              state_reg <= S_CHK;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= S_SYNC;
            end
          end
        end
        S_ADDR: begin
          if (i_Rx_DV && (sh_idx == 2'd3)) begin
            addr_reg  <= {i_Rx_Byte, sh_word[31:8]};
            state_reg <= S_DATA;
          end
        end
        S_DATA: begin
          if (i_Rx_DV && (sh_idx == 2'd3)) state_reg <= S_CHK;
        end
        S_CHK: begin
          if (i_Rx_DV) begin
            state_reg <= S_SYNC;
            if (i_Rx_Byte != sh_chk) begin
              err_reg <= 1'b1;
            end else if (cmd_reg == CMD_WRITE) begin
              if (addr_reg[1:0] != 2'b00) begin
                err_reg <= 1'b1;
              end else begin
                mem_valid_reg <= 1'b1;
                mem_addr_reg  <= addr_reg;
                mem_wdata_reg <= sh_word;
                mem_wstrb_reg <= 4'hF;
                state_reg     <= S_WRITE;
              end
            end else begin
              cpu_rst_n_reg <= (cmd_reg == CMD_GO);
            end
          end
        end
        S_WRITE: begin
          // Bytes cannot be buffered mid-handshake; they are dropped and flagged.
          if (i_Rx_DV) err_reg <= 1'b1;
          if (i_Mem_Ready) begin
            mem_valid_reg <= 1'b0;
            mem_wstrb_reg <= 4'd0;
            if (wr_count_reg != 16'hFFFF) wr_count_reg <= wr_count_reg + 16'd1;
            state_reg <= S_SYNC;
          end
        end
        default: state_reg <= S_SYNC;
      endcase
      if (tmo_hit) begin
        err_reg   <= 1'b1;
        state_reg <= S_SYNC;
      end
    end
  end

  assign o_Mem_Valid = mem_valid_reg;
  assign o_Mem_Addr  = mem_addr_reg;
  assign o_Mem_WData = mem_wdata_reg;
  assign o_Mem_WStrb = mem_wstrb_reg;
  assign o_Cpu_Rst_n = cpu_rst_n_reg;
  assign o_Err_Pulse = err_reg;
  assign o_Wr_Count  = wr_count_reg;

endmodule
